// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the RV32I multi-cycle controller:
// FSM states, opcodes, and the datapath select / ALU encodings.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multicycle_controller_alu_dec.sv
// ALU control decoder: maps the FSM's alu_op class plus IR fields to the
// concrete ALU operation.
module alu_dec
    import riscv_mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // Only R-type (op5=1) with funct7[5] set turns funct3=000 into subtract.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a shared-ALU, unified-memory RV32I multi-cycle
// datapath (lw, sw, R/I-type ALU, beq, jal).
module multicycle_controller
    import riscv_mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         imm_src,
    output logic [2:0]         alu_control,
    output logic               illegal,
    output logic               instr_done,
    output logic [STATE_W-1:0] dbg_state
);

    state_e     state_r;
    state_e     next_state_s;
    logic       illegal_r;
    logic       pc_update_s;
    logic       branch_s;
    logic       adr_src_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic       instr_done_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] imm_src_s;

    // State register and sticky illegal flag; only reset leaves ILLEGAL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_FETCH;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            illegal_r <= illegal_r | (next_state_s == S_ILLEGAL);
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        next_state_s = state_r;
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        instr_done_s = 1'b0;
        result_src_s = RES_ALUOUT;
        alu_src_a_s  = SRCA_PC;
        alu_src_b_s  = SRCB_RS2;
        alu_op_s     = ALU_OP_ADD;
        case (state_r)
            S_FETCH: begin
                ir_write_s   = 1'b1;
                alu_src_b_s  = SRCB_FOUR;
                result_src_s = RES_ALURESULT;
                pc_update_s  = 1'b1;
                next_state_s = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut for a possible beq.
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_IMM;
                case (opcode)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_R:         next_state_s = S_EXEC_R;
                    OP_I:         next_state_s = S_EXEC_I;
                    OP_BEQ:       next_state_s = S_BEQ;
                    OP_JAL:       next_state_s = S_JAL;
                    default:      next_state_s = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s  = SRCA_RS1;
                alu_src_b_s  = SRCB_IMM;
                next_state_s = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src_s    = 1'b1;
                next_state_s = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_s = RES_DATA;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_s    = 1'b1;
                mem_write_s  = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a_s  = SRCA_RS1;
                alu_op_s     = ALU_OP_FUNCT;
                next_state_s = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a_s  = SRCA_RS1;
                alu_src_b_s  = SRCB_IMM;
                alu_op_s     = ALU_OP_FUNCT;
                next_state_s = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a_s  = SRCA_RS1;
                alu_op_s     = ALU_OP_SUB;
                branch_s     = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = S_FETCH;
            end
            S_JAL: begin
                // PC <- branch target (ALUOut) while OldPC+4 becomes the link value.
                alu_src_a_s  = SRCA_OLDPC;
                alu_src_b_s  = SRCB_FOUR;
                pc_update_s  = 1'b1;
                next_state_s = S_ALUWB;
            end
            S_ILLEGAL: begin
                next_state_s = S_ILLEGAL;
            end
            default: begin
                next_state_s = S_ILLEGAL;
            end
        endcase
    end

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        imm_src_s = IMM_I;
        case (opcode)
            OP_LW, OP_I: imm_src_s = IMM_I;
            OP_SW:       imm_src_s = IMM_S;
            OP_BEQ:      imm_src_s = IMM_B;
            OP_JAL:      imm_src_s = IMM_J;
            default:     imm_src_s = IMM_I;
        endcase
    end

    alu_dec u_alu_dec (
        .alu_op      (alu_op_s),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (opcode[5]),
        .alu_control (alu_control)
    );

    // Strobes are held off for the whole reset cycle, whatever the state.
    assign pc_write   = rst_n & (pc_update_s | (branch_s & zero));
    assign ir_write   = rst_n & ir_write_s;
    assign reg_write  = rst_n & reg_write_s;
    assign mem_write  = rst_n & mem_write_s;
    assign instr_done = rst_n & instr_done_s;
    assign adr_src    = adr_src_s;
    assign result_src = result_src_s;
    assign alu_src_a  = alu_src_a_s;
    assign alu_src_b  = alu_src_b_s;
    assign imm_src    = imm_src_s;
    assign illegal    = illegal_r;
    assign dbg_state  = STATE_W'(state_r);

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller: a per-instruction
// step model predicts every output on every cycle.
module tb_multicycle_controller;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_JAL = 5, C_ILL = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal, instr_done;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal),
        .instr_done(instr_done), .dbg_state(dbg_state)
    );

    logic [17:0] obs_vec;
    logic [4:0]  obs_strobes;
    assign obs_vec = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                      alu_src_a, alu_src_b, imm_src, alu_control, illegal, instr_done};
    assign obs_strobes = {pc_write, ir_write, reg_write, mem_write, instr_done};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int instr_len(input int cls);
        case (cls)
            C_LW:    return 5;
            C_SW:    return 4;
            C_R:     return 4;
            C_I:     return 4;
            C_BEQ:   return 3;
            C_JAL:   return 4;
            default: return 2;
        endcase
    endfunction

    function automatic logic [6:0] opcode_of(input int cls);
        case (cls)
            C_LW:    return 7'b0000011;
            C_SW:    return 7'b0100011;
            C_R:     return 7'b0110011;
            C_I:     return 7'b0010011;
            C_BEQ:   return 7'b1100011;
            C_JAL:   return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Expected outputs for step 'step' of an instruction of class 'cls'.
    function automatic logic [17:0] exp_vec(input int cls, input int step, input logic [6:0] op,
                                            input logic [2:0] f3, input logic f7, input logic z);
        string      ph;
        logic       pcu = 1'b0, br = 1'b0, adr = 1'b0, mw = 1'b0, irw = 1'b0, rw = 1'b0;
        logic       done = 1'b0, ill = 1'b0;
        logic [1:0] res = 2'b00, sa = 2'b00, sb = 2'b00, aop = 2'b00, imm = 2'b00;
        logic [2:0] ac;
        if (step == 0) ph = "fetch";
        else if (step == 1) ph = "decode";
        else if (cls == C_ILL) ph = "illegal";
        else if (cls == C_LW) ph = (step == 2) ? "memadr" : (step == 3) ? "memread" : "memwb";
        else if (cls == C_SW) ph = (step == 2) ? "memadr" : "memwrite";
        else if (cls == C_R) ph = (step == 2) ? "exec_r" : "aluwb";
        else if (cls == C_I) ph = (step == 2) ? "exec_i" : "aluwb";
        else if (cls == C_BEQ) ph = "beq";
        else ph = (step == 2) ? "jal" : "aluwb";

        if (ph == "fetch") begin irw = 1'b1; sb = 2'b10; res = 2'b10; pcu = 1'b1; end
        if (ph == "decode") begin sa = 2'b01; sb = 2'b01; end
        if (ph == "memadr") begin sa = 2'b10; sb = 2'b01; end
        if (ph == "memread") adr = 1'b1;
        if (ph == "memwb") begin res = 2'b01; rw = 1'b1; done = 1'b1; end
        if (ph == "memwrite") begin adr = 1'b1; mw = 1'b1; done = 1'b1; end
        if (ph == "exec_r") begin sa = 2'b10; aop = 2'b10; end
        if (ph == "exec_i") begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
        if (ph == "aluwb") begin rw = 1'b1; done = 1'b1; end
        if (ph == "beq") begin sa = 2'b10; aop = 2'b01; br = 1'b1; done = 1'b1; end
        if (ph == "jal") begin sa = 2'b01; sb = 2'b10; pcu = 1'b1; end
        if (ph == "illegal") ill = 1'b1;

        if (aop == 2'b01) ac = 3'b001;
        else if (aop == 2'b10) begin
            if (f3 == 3'b000) ac = (op[5] && f7) ? 3'b001 : 3'b000;
            else if (f3 == 3'b010) ac = 3'b101;
            else if (f3 == 3'b110) ac = 3'b011;
            else if (f3 == 3'b111) ac = 3'b010;
            else ac = 3'b000;
        end else ac = 3'b000;

        if (op == 7'b0100011) imm = 2'b01;
        else if (op == 7'b1100011) imm = 2'b10;
        else if (op == 7'b1101111) imm = 2'b11;
        else imm = 2'b00;

        return {pcu | (br & z), adr, mw, irw, rw, res, sa, sb, imm, ac, ill, done};
    endfunction

    // Assert reset for one cycle from the current point; strobes must stay low.
    task automatic reset_cycle(input string tag);
        rst_n = 1'b0;
        zero  = 1'b1;
        @(negedge clk);
        check_eq(tag, 32'(obs_strobes), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Runs one instruction from FETCH; abort_at >= 0 resets at that step,
    // extra adds cycles after the last step (used to watch ILLEGAL hold).
    task automatic run_instr(input int cls, input logic [6:0] op, input int abort_at, input int extra);
        int n;
        n        = instr_len(cls) + extra;
        opcode   = op;
        funct3   = 3'($urandom);
        funct7b5 = 1'($urandom);
        for (int s = 0; s < n; s++) begin
            if (s == abort_at) begin
                reset_cycle($sformatf("abort_c%0d_s%0d", cls, s));
                return;
            end
            zero = 1'($urandom);
            @(negedge clk);
            check_eq($sformatf("c%0d_s%0d", cls, (s < instr_len(cls)) ? s : instr_len(cls)),
                     32'(obs_vec),
                     32'(exp_vec(cls, (s < instr_len(cls)) ? s : instr_len(cls),
                                 op, funct3, funct7b5, zero)));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] bad_op;
        int         cls;
        rst_n    = 1'b0;
        opcode   = 7'b0000000;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        zero     = 1'b1;
        @(negedge clk);
        check_eq("reset_strobes", 32'(obs_strobes), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed: each class once, then sub/or R-type decode.
        for (int c = C_LW; c <= C_JAL; c++) run_instr(c, opcode_of(c), -1, 0);
        opcode = opcode_of(C_R);
        funct3 = 3'b000; funct7b5 = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk);
        check_eq("sub_alu_control", 32'(alu_control), 32'd1);
        @(posedge clk); #1;
        funct3 = 3'b110;
        @(negedge clk);
        check_eq("or_alu_control_aluwb_add", 32'(alu_control), 32'd0);
        check_eq("aluwb_reg_write", 32'(reg_write), 32'd1);
        @(posedge clk); #1;

        // Random legal instructions with occasional aborts.
        for (int i = 0; i < 80; i++) begin
            cls = int'($urandom_range(0, 5));
            if (i % 17 == 5) run_instr(cls, opcode_of(cls),
                                       int'($urandom_range(1, instr_len(cls) - 1)), 0);
            else run_instr(cls, opcode_of(cls), -1, 0);
        end

        // Abort mid-MEMREAD and mid-MEMWRITE.
        run_instr(C_LW, opcode_of(C_LW), 3, 0);
        run_instr(C_SW, opcode_of(C_SW), 3, 0);
        run_instr(C_LW, opcode_of(C_LW), -1, 0);

        // Illegal opcode 0000000, held for 10 cycles, then reset to recover.
        run_instr(C_ILL, 7'b0000000, -1, 10);
        reset_cycle("ill_reset");
        run_instr(C_JAL, opcode_of(C_JAL), -1, 0);

        // A random unsupported opcode.
        bad_op = 7'($urandom);
        while (bad_op == 7'b0000011 || bad_op == 7'b0100011 || bad_op == 7'b0110011 ||
               bad_op == 7'b0010011 || bad_op == 7'b1100011 || bad_op == 7'b1101111)
            bad_op = 7'($urandom);
        run_instr(C_ILL, bad_op, -1, 3);
        reset_cycle("ill_reset2");
        run_instr(C_BEQ, opcode_of(C_BEQ), -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
